// File: rtl/operand_sequencer_pkg.sv
// Shared ALU definitions: datapath width defaults and the sequencer state encoding.
// Both the adder and the operand sequencer take their default width from here,
// so the two sides of the a_out/b_out -> sum_in path always agree.
package operand_sequencer_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_SUM = 2'd2,
        S_OUT = 2'd3
    } state_t;

endpackage

// File: rtl/operand_sequencer_if.sv
// Operand input channel and result output channel of the operand sequencer.
//   din/din_valid/din_ready             : serial operand stream (A then B)
//   res/carry/res_valid/res_ready       : result channel
//   op_count                            : completed-result counter
// master = producer/consumer side, slave = sequencer side.
interface operand_sequencer_if #(
    parameter int unsigned WIDTH = operand_sequencer_pkg::WIDTH_DEF,
    parameter int unsigned CNT_W = operand_sequencer_pkg::CNT_W_DEF
);

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] op_count;

    modport master (
        output din, din_valid, res_ready,
        input  din_ready, res, carry, res_valid, op_count
    );

    modport slave (
        input  din, din_valid, res_ready,
        output din_ready, res, carry, res_valid, op_count
    );

endinterface

// File: rtl/operand_sequencer.sv
// Control stage for the ALU adder: loads A then B from the operand channel,
// drives them to the sibling adder, captures the adder sum one cycle later and
// offers it with carry-out and a running operation count on the result channel.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : operand input channel and result output channel
//   a_out, b_out : registered operands to the adder A/B inputs
//   sum_in       : adder output Y (combinational from a_out/b_out)
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    operand_sequencer_if.slave  bus,
    output logic [WIDTH-1:0]    a_out,
    output logic [WIDTH-1:0]    b_out,
    input  logic [WIDTH-1:0]    sum_in
);

    state_t           state;
    state_t           state_next;
    logic             load_a;
    logic             load_b;
    logic             load_res;
    logic             count_en;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             res_valid_q;
    logic [CNT_W-1:0] count_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath load enables; din_valid alone is a transfer in
    // S_A/S_B because din_ready is high there whenever reset is released.
    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_res   = 1'b0;
        count_en   = 1'b0;
        case (state)
            S_A: begin
                if (bus.din_valid) begin
                    load_a     = 1'b1;
                    state_next = S_B;
                end
            end
            S_B: begin
                if (bus.din_valid) begin
                    load_b     = 1'b1;
                    state_next = S_SUM;
                end
            end
            S_SUM: begin
                load_res   = 1'b1;
                state_next = S_OUT;
            end
            S_OUT: begin
                if (bus.res_ready) begin
                    count_en   = 1'b1;
                    state_next = S_A;
                end
            end
            default: begin
                state_next = S_A;
            end
        endcase
    end

    // Operand, result and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out       <= '0;
            b_out       <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            res_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            if (load_a) begin
                a_out <= bus.din;
            end
            if (load_b) begin
                b_out <= bus.din;
            end
            if (load_res) begin
                res_q   <= sum_in;
                // A wrapped unsigned sum is smaller than either operand.
                carry_q <= (sum_in < a_out);
            end
            res_valid_q <= (state_next == S_OUT);
            if (count_en) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.din_ready = !rst && ((state == S_A) || (state == S_B));
    assign bus.res       = res_q;
    assign bus.carry     = carry_q;
    assign bus.res_valid = res_valid_q;
    assign bus.op_count  = count_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer. Models the sibling adder as a
// continuous add and checks every cycle of each operation against a reference
// built from plain 5-bit arithmetic and an operation counter.
module tb_operand_sequencer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] sum_in;

    operand_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    operand_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .a_out  (a_out),
        .b_out  (b_out),
        .sum_in (sum_in)
    );

    // Sibling adder
    assign sum_in = WIDTH'(a_out + b_out);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] mres;
    logic             mcarry;
    int               mcount;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a"},        a_out, 0);
        check({tag, "_b"},        b_out, 0);
        check({tag, "_res"},      bus.res, 0);
        check({tag, "_carry"},    bus.carry, 0);
        check({tag, "_valid"},    bus.res_valid, 0);
        check({tag, "_count"},    bus.op_count, 0);
        check({tag, "_dinready"}, bus.din_ready, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check_reset_values("rst_async");
        ma = '0; mb = '0; mres = '0; mcarry = 1'b0; mcount = 0;
        tick();
        check_reset_values("rst_held");
        bus.din_valid = 1'b0;
        bus.res_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_release_ready", bus.din_ready, 1);
    endtask

    // One operation; abort=1 resets in S_B, abort=2 resets in S_OUT.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int pre_gap, input int mid_gap, input int bp,
                         input int abort);
        logic [WIDTH:0] full;
        full = (WIDTH+1)'(a) + (WIDTH+1)'(b);
        bus.res_ready = (bp == 0);

        for (int i = 0; i < pre_gap; i++) begin
            bus.din_valid = 1'b0;
            bus.din       = WIDTH'($urandom);
            tick();
            check("stall_a_ready", bus.din_ready, 1);
            check("stall_a_hold", a_out, ma);
        end

        bus.din       = a;
        bus.din_valid = 1'b1;
        tick();
        ma = a;
        check("a_load", a_out, ma);
        check("a_b_hold", b_out, mb);
        check("sb_ready", bus.din_ready, 1);
        if (abort == 1) begin
            apply_reset();
            return;
        end

        for (int i = 0; i < mid_gap; i++) begin
            bus.din_valid = 1'b0;
            bus.din       = WIDTH'($urandom);
            tick();
            check("stall_b_a", a_out, ma);
            check("stall_b_hold", b_out, mb);
            check("stall_b_valid", bus.res_valid, 0);
        end

        bus.din       = b;
        bus.din_valid = 1'b1;
        tick();
        mb = b;
        check("b_load", b_out, mb);
        check("ssum_ready", bus.din_ready, 0);
        check("ssum_valid", bus.res_valid, 0);

        bus.din_valid = 1'($urandom);
        bus.din       = WIDTH'($urandom);
        tick();
        mres   = full[WIDTH-1:0];
        mcarry = full[WIDTH];
        check("out_valid", bus.res_valid, 1);
        check("out_res", bus.res, mres);
        check("out_carry", bus.carry, mcarry);
        check("out_ready", bus.din_ready, 0);
        check("out_count", bus.op_count, mcount);
        if (abort == 2) begin
            apply_reset();
            return;
        end

        for (int i = 0; i < bp; i++) begin
            bus.din_valid = 1'($urandom);
            bus.din       = WIDTH'($urandom);
            tick();
            check("bp_valid", bus.res_valid, 1);
            check("bp_res", bus.res, mres);
            check("bp_carry", bus.carry, mcarry);
            check("bp_ready", bus.din_ready, 0);
            check("bp_count", bus.op_count, mcount);
        end

        bus.res_ready = 1'b1;
        tick();
        mcount = (mcount + 1) % (1 << CNT_W);
        check("done_valid", bus.res_valid, 0);
        check("done_count", bus.op_count, mcount);
        check("done_ready", bus.din_ready, 1);
        check("done_res_hold", bus.res, mres);
        check("done_carry_hold", bus.carry, mcarry);
        check("done_a_hold", a_out, ma);
        bus.din_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        rst           = 1'b1;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.res_ready = 1'b0;
        ma = '0; mb = '0; mres = '0; mcarry = 1'b0; mcount = 0;
        #3;
        check_reset_values("reset");
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("release_ready", bus.din_ready, 1);

        // Basic add, then carry/wrap cases
        do_op(4'h3, 4'h4, 0, 0, 0, 0);
        check("basic_count", bus.op_count, 1);
        do_op(4'hF, 4'h1, 0, 0, 0, 0);
        do_op(4'h9, 4'h7, 0, 0, 0, 0);
        do_op(4'h8, 4'h7, 0, 0, 0, 0);

        // Backpressure and producer stalls
        do_op(4'h5, 4'h6, 0, 0, 10, 0);
        do_op(4'hA, 4'hC, 3, 4, 0, 0);

        // Reset in S_B and in S_OUT, then recovery
        do_op(4'h9, 4'h0, 0, 0, 0, 1);
        do_op(4'h2, 4'h2, 0, 0, 0, 0);
        do_op(4'hE, 4'hD, 1, 0, 2, 2);
        do_op(4'h2, 4'h2, 0, 0, 0, 0);
        check("recover_res", bus.res, 4);

        // Randomized operations with random stalls and backpressure
        for (int n = 0; n < 40; n++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 0);
        end

        // Back-to-back operations through the counter wrap
        for (int n = 0; n < 256; n++) begin
            c0 = cyc;
            do_op(WIDTH'($urandom), WIDTH'($urandom), 0, 0, 0, 0);
            check("op_cycles", cyc - c0, 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
